// File: rtl/rj_decoder.sv
// rj_decoder: decodes ring/Johnson code words to a phase index, tracks lock and counts lock losses.
// Ports:
//   clk      rising-edge clock; rst async active-low reset
//   rj       code mode (0 ring, 1 Johnson), sampled with en
//   en       sample enable
//   q_in     code word from the counter
//   clr_err  synchronous clear of err_cnt
//   idx      decoded phase index of the last legal sample
//   legal    last sample was a legal code word
//   locked   lock FSM is in LOCKED
//   seq_err  one-cycle pulse on loss of lock
//   err_cnt  saturating count of lock losses
module rj_decoder #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(2 * W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rj,
  input  logic             en,
  input  logic [W-1:0]     q_in,
  input  logic             clr_err,
  output logic [IW-1:0]    idx,
  output logic             legal,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} state_t;
  state_t state_q, state_d, state_eff;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic mode_q, mode_d;
  logic [IW-1:0] idx_q, idx_d, dec_idx, idx_max;
  logic legal_q, legal_d, seq_q, seq_d, dec_legal, succ, err_ev;
  logic [ERR_W-1:0] err_q, err_d;
  function automatic logic [W-1:0] low_ones(input int k);
    return {W{1'b1}} >> (W - k);
  endfunction
  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = '0;
    for (int k = 0; k < W; k++) begin
      if (rj) begin
        if (q_in == low_ones(k)) begin
          dec_legal = 1'b1;
          dec_idx   = IW'(k);
        end
        if (q_in == ~low_ones(k)) begin
          dec_legal = 1'b1;
          dec_idx   = IW'(W + k);
        end
      end else if (q_in == low_ones(k) + 1'b1) begin
        dec_legal = 1'b1;
        dec_idx   = IW'(k);
      end
    end
  end
  // a mode change restarts tracking, so the successor test only ever sees the new mode
  assign idx_max   = rj ? IW'(2 * W - 1) : IW'(W - 1);
  assign succ      = dec_legal && (idx_q == idx_max ? dec_idx == '0 : dec_idx == idx_q + 1'b1);
  assign cnt_inc   = cnt_q + 4'd1;
  assign state_eff = (rj != mode_q) ? UNLOCKED : state_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    legal_d = legal_q;
    err_ev  = 1'b0;
    if (en) begin
      mode_d  = rj;
      legal_d = dec_legal;
      idx_d   = dec_legal ? dec_idx : idx_q;
      case (state_eff)
        UNLOCKED: begin
          state_d = dec_legal ? TRACK : UNLOCKED;
          cnt_d   = '0;
        end
        TRACK: begin
          state_d = !dec_legal ? UNLOCKED : (succ && cnt_inc == 4'(LOCK_CNT)) ? LOCKED : TRACK;
          cnt_d   = succ ? cnt_inc : '0;
        end
        default: begin
          err_ev  = !succ;
          state_d = succ ? LOCKED : dec_legal ? TRACK : UNLOCKED;
          cnt_d   = '0;
        end
      endcase
    end
  end
  // clear beats a coincident error event; the pulse itself still fires
  assign seq_d = err_ev;
  assign err_d = clr_err ? '0 : (err_ev && !(&err_q)) ? err_q + 1'b1 : err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      legal_q <= 1'b0;
      seq_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      legal_q <= legal_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end
  assign idx     = idx_q;
  assign legal   = legal_q;
  assign locked  = state_q == LOCKED;
  assign seq_err = seq_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_rj_decoder.sv
// tb_rj_decoder: directed vector bench for rj_decoder (W=4, LOCK_CNT=3, ERR_W=2).
module tb_rj_decoder;
  logic clk = 1'b0, rst = 1'b0, rj = 1'b0, en = 1'b0, clr_err = 1'b0;
  logic [3:0] q_in = '0;
  logic [2:0] idx;
  logic legal, locked, seq_err;
  logic [1:0] err_cnt;
  int checks = 0, passed = 0;
  typedef struct {
    logic rj, en, clr;
    logic [3:0] q;
    logic [2:0] idx;
    logic legal, locked, seq;
    logic [1:0] err;
  } vec_t;
  vec_t v[$];
  rj_decoder #(.W(4), .LOCK_CNT(3), .ERR_W(2)) dut (
    .clk(clk), .rst(rst), .rj(rj), .en(en), .q_in(q_in), .clr_err(clr_err),
    .idx(idx), .legal(legal), .locked(locked), .seq_err(seq_err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  function automatic void add(input logic r, e, c, input logic [3:0] q, input logic [2:0] i,
                              input logic l, lk, s, input logic [1:0] er);
    vec_t t;
    t.rj = r; t.en = e; t.clr = c; t.q = q; t.idx = i; t.legal = l; t.locked = lk; t.seq = s; t.err = er;
    v.push_back(t);
  endfunction
  task automatic check(input string n, input logic [2:0] i, input logic l, lk, s, input logic [1:0] er);
    checks++;
    if ({idx, legal, locked, seq_err, err_cnt} === {i, l, lk, s, er}) passed++;
    else $display("FAIL %s: got idx=%0d legal=%0b locked=%0b seq_err=%0b err_cnt=%0d, expected idx=%0d legal=%0b locked=%0b seq_err=%0b err_cnt=%0d",
                  n, idx, legal, locked, seq_err, err_cnt, i, l, lk, s, er);
  endtask
  task automatic step(input string n, input logic r, e, c, input logic [3:0] q, input logic [2:0] i,
                      input logic l, lk, s, input logic [1:0] er);
    rj = r; en = e; clr_err = c; q_in = q;
    @(posedge clk);
    #1;
    check(n, i, l, lk, s, er);
  endtask
  initial begin
    add(0,1,0,4'b0001, 0,1,0,0,0);
    add(0,1,0,4'b0010, 1,1,0,0,0);
    add(0,1,0,4'b0100, 2,1,0,0,0);
    add(0,1,0,4'b1000, 3,1,1,0,0);
    add(0,1,0,4'b0001, 0,1,1,0,0);
    add(0,1,0,4'b0010, 1,1,1,0,0);
    add(0,1,0,4'b0100, 2,1,1,0,0);
    add(0,1,0,4'b0100, 2,1,0,1,1);
    add(0,1,0,4'b0110, 2,0,0,0,1);
    add(0,1,0,4'b0001, 0,1,0,0,1);
    add(0,1,0,4'b0010, 1,1,0,0,1);
    add(0,1,0,4'b0100, 2,1,0,0,1);
    add(0,1,0,4'b1000, 3,1,1,0,1);
    add(1,1,0,4'b0011, 2,1,0,0,1);
    add(1,1,0,4'b0111, 3,1,0,0,1);
    add(1,1,0,4'b1111, 4,1,0,0,1);
    add(1,1,0,4'b1110, 5,1,1,0,1);
    add(1,1,0,4'b1100, 6,1,1,0,1);
    add(1,1,0,4'b1000, 7,1,1,0,1);
    add(1,1,0,4'b0000, 0,1,1,0,1);
    add(1,1,0,4'b0001, 1,1,1,0,1);
    add(1,1,0,4'b0101, 1,0,0,1,2);
    add(1,0,0,4'b0011, 1,0,0,0,2);
    add(0,0,0,4'b1111, 1,0,0,0,2);
    add(0,1,0,4'b0001, 0,1,0,0,2);
    add(0,1,0,4'b0010, 1,1,0,0,2);
    add(0,1,0,4'b0100, 2,1,0,0,2);
    add(0,1,0,4'b1000, 3,1,1,0,2);
    add(0,1,0,4'b1000, 3,1,0,1,3);
    add(0,1,0,4'b0001, 0,1,0,0,3);
    add(0,1,0,4'b0010, 1,1,0,0,3);
    add(0,1,0,4'b0100, 2,1,1,0,3);
    add(0,1,0,4'b0100, 2,1,0,1,3);
    add(0,1,0,4'b1000, 3,1,0,0,3);
    add(0,1,0,4'b0001, 0,1,0,0,3);
    add(0,1,0,4'b0010, 1,1,1,0,3);
    add(0,1,0,4'b0010, 1,1,0,1,3);
    add(0,1,0,4'b0100, 2,1,0,0,3);
    add(0,1,0,4'b1000, 3,1,0,0,3);
    add(0,1,0,4'b0001, 0,1,1,0,3);
    add(0,1,1,4'b0001, 0,1,0,1,0);
    add(0,1,0,4'b0010, 1,1,0,0,0);
    add(0,1,0,4'b0001, 0,1,0,0,0);
    add(0,1,0,4'b0010, 1,1,0,0,0);
    add(0,1,0,4'b0100, 2,1,0,0,0);
    add(0,1,0,4'b1000, 3,1,1,0,0);
    #1;
    check("reset_initial", 0, 0, 0, 0, 0);
    en = 1'b1; q_in = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 0, 0, 0, 0, 0);
    rst = 1'b1;
    foreach (v[i])
      step($sformatf("vec%0d", i), v[i].rj, v[i].en, v[i].clr, v[i].q, v[i].idx, v[i].legal, v[i].locked, v[i].seq, v[i].err);
    #2 rst = 1'b0;
    #1 check("async_reset", 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    step("relock1", 0, 1, 0, 4'b0010, 1, 1, 0, 0, 0);
    step("relock2", 0, 1, 0, 4'b0100, 2, 1, 0, 0, 0);
    step("relock3", 0, 1, 0, 4'b1000, 3, 1, 0, 0, 0);
    step("relock4", 0, 1, 0, 4'b0001, 0, 1, 1, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
